// File: rtl/wb_rr_arbiter2.sv
// Round-robin arbiter sharing one pipelined Wishbone slave between two masters.
// One request in flight at a time, with a response timeout guarding against a dead slave.
module wb_rr_arbiter2 #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255,
  localparam int SEL_W      = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_adr_i,
  input  logic [SEL_W-1:0]  m0_sel_i,
  input  logic [DATA_W-1:0] m0_dat_i,
  output logic [DATA_W-1:0] m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic              m0_rty_o,
  output logic              m0_stall_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [SEL_W-1:0]  m1_sel_i,
  input  logic [DATA_W-1:0] m1_dat_i,
  output logic [DATA_W-1:0] m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              m1_rty_o,
  output logic              m1_stall_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_adr_o,
  output logic [SEL_W-1:0]  s_sel_o,
  output logic [DATA_W-1:0] s_dat_o,
  input  logic [DATA_W-1:0] s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  input  logic              s_rty_i,
  input  logic              s_stall_i
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;

  logic req0, req1;
  logic accept0, accept1;
  logic owner_cyc;
  logic tmo_hit;
  logic fwd_ack, fwd_err, fwd_rty;
  logic cyc, stb;

  assign req0      = m0_cyc_i & m0_stb_i;
  assign req1      = m1_cyc_i & m1_stb_i;
  assign owner_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
  assign tmo_hit   = (TIMEOUT_CYC != 0) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYC));

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    adr_d        = adr_q;
    sel_d        = sel_q;
    dat_d        = dat_q;
    tmo_cnt_d    = tmo_cnt_q;
    accept0      = 1'b0;
    accept1      = 1'b0;
    fwd_ack      = 1'b0;
    fwd_err      = 1'b0;
    fwd_rty      = 1'b0;
    cyc          = 1'b0;
    stb          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // On a tie the master that was not served last wins.
        if (req0 && (!req1 || last_owner_q)) begin
          accept0 = 1'b1;
        end else if (req1) begin
          accept1 = 1'b1;
        end
        if (accept0 || accept1) begin
          owner_d      = accept1;
          last_owner_d = accept1;
          we_d         = accept1 ? m1_we_i  : m0_we_i;
          adr_d        = accept1 ? m1_adr_i : m0_adr_i;
          sel_d        = accept1 ? m1_sel_i : m0_sel_i;
          dat_d        = accept1 ? m1_dat_i : m0_dat_i;
          tmo_cnt_d    = '0;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        cyc = ~tmo_hit;
        stb = (state_q == ST_ISSUE) & ~tmo_hit;
        // Abort beats timeout beats slave response; a timeout cycle drops cyc itself.
        if (!owner_cyc) begin
          state_d = ST_IDLE;
        end else if (tmo_hit) begin
          fwd_err = 1'b1;
          state_d = ST_IDLE;
        end else if (s_err_i || s_rty_i || s_ack_i) begin
          fwd_err = s_err_i;
          fwd_rty = ~s_err_i & s_rty_i;
          fwd_ack = ~s_err_i & ~s_rty_i & s_ack_i;
          state_d = ST_IDLE;
        end else begin
          if (state_q == ST_ISSUE && !s_stall_i) begin
            state_d = ST_WAIT;
          end
          if (TIMEOUT_CYC != 0) begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      we_q         <= 1'b0;
      adr_q        <= '0;
      sel_q        <= '0;
      dat_q        <= '0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      sel_q        <= sel_d;
      dat_q        <= dat_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  assign s_cyc_o    = cyc;
  assign s_stb_o    = stb;
  assign s_we_o     = we_q;
  assign s_adr_o    = adr_q;
  assign s_sel_o    = sel_q;
  assign s_dat_o    = dat_q;

  assign m0_dat_o   = s_dat_i;
  assign m1_dat_o   = s_dat_i;
  assign m0_ack_o   = fwd_ack & ~owner_q;
  assign m1_ack_o   = fwd_ack &  owner_q;
  assign m0_err_o   = fwd_err & ~owner_q;
  assign m1_err_o   = fwd_err &  owner_q;
  assign m0_rty_o   = fwd_rty & ~owner_q;
  assign m1_rty_o   = fwd_rty &  owner_q;
  assign m0_stall_o = ~accept0;
  assign m1_stall_o = ~accept1;

endmodule

// File: tb/tb_wb_rr_arbiter2.sv
// Bench for wb_rr_arbiter2: directed scenarios followed by random traffic, all checked
// each cycle against a transaction-level reference model.
module tb_wb_rr_arbiter2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic          m_cyc [2];
  logic          m_stb [2];
  logic          m_we  [2];
  logic [AW-1:0] m_adr [2];
  logic [SW-1:0] m_sel [2];
  logic [DW-1:0] m_dat [2];
  logic [DW-1:0] sl_dat;
  logic          sl_ack, sl_err, sl_rty, sl_stall;

  logic [DW-1:0] m0_dat_o, m1_dat_o;
  logic          m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_rty_o, m1_rty_o;
  logic          m0_stall_o, m1_stall_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_adr_o;
  logic [SW-1:0] s_sel_o;
  logic [DW-1:0] s_dat_o;

  int total = 0;
  int bad   = 0;

  // reference model: one outstanding transaction
  bit            md_busy;
  int            md_owner;
  int            md_last;
  int            md_age;
  bit            md_stb;
  logic          md_we;
  logic [AW-1:0] md_adr;
  logic [SW-1:0] md_sel;
  logic [DW-1:0] md_dat;

  // observations from the most recent step
  logic          g_stall [2];
  logic          g_ack   [2];
  logic          g_err   [2];
  logic          g_rty   [2];
  logic          g_cyc, g_stb;
  logic [AW-1:0] g_adr;
  logic [DW-1:0] g_sdat;
  logic [DW-1:0] g_mdat   [2];

  int grants[$];
  int ack_cnt [2];

  wb_rr_arbiter2 #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .m0_cyc_i   (m_cyc[0]),
    .m0_stb_i   (m_stb[0]),
    .m0_we_i    (m_we[0]),
    .m0_adr_i   (m_adr[0]),
    .m0_sel_i   (m_sel[0]),
    .m0_dat_i   (m_dat[0]),
    .m0_dat_o   (m0_dat_o),
    .m0_ack_o   (m0_ack_o),
    .m0_err_o   (m0_err_o),
    .m0_rty_o   (m0_rty_o),
    .m0_stall_o (m0_stall_o),
    .m1_cyc_i   (m_cyc[1]),
    .m1_stb_i   (m_stb[1]),
    .m1_we_i    (m_we[1]),
    .m1_adr_i   (m_adr[1]),
    .m1_sel_i   (m_sel[1]),
    .m1_dat_i   (m_dat[1]),
    .m1_dat_o   (m1_dat_o),
    .m1_ack_o   (m1_ack_o),
    .m1_err_o   (m1_err_o),
    .m1_rty_o   (m1_rty_o),
    .m1_stall_o (m1_stall_o),
    .s_cyc_o    (s_cyc_o),
    .s_stb_o    (s_stb_o),
    .s_we_o     (s_we_o),
    .s_adr_o    (s_adr_o),
    .s_sel_o    (s_sel_o),
    .s_dat_o    (s_dat_o),
    .s_dat_i    (sl_dat),
    .s_ack_i    (sl_ack),
    .s_err_i    (sl_err),
    .s_rty_i    (sl_rty),
    .s_stall_i  (sl_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    for (int n = 0; n < 2; n++) begin
      m_cyc[n] = 1'b0; m_stb[n] = 1'b0; m_we[n] = 1'b0;
      m_adr[n] = '0;   m_sel[n] = '0;   m_dat[n] = '0;
    end
    sl_dat = '0; sl_ack = 1'b0; sl_err = 1'b0; sl_rty = 1'b0; sl_stall = 1'b0;
  endtask

  task automatic model_reset();
    md_busy = 1'b0; md_owner = 0; md_last = 1; md_age = 0; md_stb = 1'b0;
    md_we = 1'b0; md_adr = '0; md_sel = '0; md_dat = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("rst_s_cyc", s_cyc_o, 1'b0);
    check("rst_s_stb", s_stb_o, 1'b0);
    check("rst_s_adr", s_adr_o, '0);
    check("rst_stall", {m1_stall_o, m0_stall_o}, 2'b11);
    check("rst_resp", {m1_ack_o, m0_ack_o, m1_err_o, m0_err_o, m1_rty_o, m0_rty_o}, 6'b0);
    rst_n = 1'b1;
  endtask

  // Called just after a rising edge with inputs already driven; checks mid-cycle and
  // advances the model across the next edge.
  task automatic step();
    bit req [2];
    int grant, kind;
    bit abort, e_cyc, e_stb;
    #4;
    g_stall[0] = m0_stall_o; g_stall[1] = m1_stall_o;
    g_ack[0]   = m0_ack_o;   g_ack[1]   = m1_ack_o;
    g_err[0]   = m0_err_o;   g_err[1]   = m1_err_o;
    g_rty[0]   = m0_rty_o;   g_rty[1]   = m1_rty_o;
    g_mdat[0]  = m0_dat_o;   g_mdat[1]  = m1_dat_o;
    g_cyc = s_cyc_o; g_stb = s_stb_o; g_adr = s_adr_o; g_sdat = s_dat_o;
    for (int n = 0; n < 2; n++) req[n] = m_cyc[n] & m_stb[n];
    grant = -1; kind = 0; abort = 1'b0; e_cyc = 1'b0; e_stb = 1'b0;
    if (!md_busy) begin
      if (req[0] && req[1]) grant = 1 - md_last;
      else if (req[0])      grant = 0;
      else if (req[1])      grant = 1;
    end else begin
      e_cyc = (md_age < TMO);
      e_stb = md_stb && e_cyc;
      if (!m_cyc[md_owner])            abort = 1'b1;
      else if (md_age == TMO || sl_err) kind = 2;
      else if (sl_rty)                  kind = 3;
      else if (sl_ack)                  kind = 1;
    end
    for (int n = 0; n < 2; n++) begin
      check($sformatf("stall%0d", n), g_stall[n], grant != n);
      check($sformatf("ack%0d", n), g_ack[n], kind == 1 && md_owner == n);
      check($sformatf("err%0d", n), g_err[n], kind == 2 && md_owner == n);
      check($sformatf("rty%0d", n), g_rty[n], kind == 3 && md_owner == n);
      check($sformatf("mdat%0d", n), g_mdat[n], sl_dat);
    end
    check("s_cyc", g_cyc, e_cyc);
    check("s_stb", g_stb, e_stb);
    check("s_adr", g_adr, md_adr);
    check("s_sel", s_sel_o, md_sel);
    check("s_dat", g_sdat, md_dat);
    check("s_we", s_we_o, md_we);
    if (grant >= 0) begin
      md_busy = 1'b1; md_owner = grant; md_last = grant; md_age = 0; md_stb = 1'b1;
      md_we = m_we[grant]; md_adr = m_adr[grant]; md_sel = m_sel[grant]; md_dat = m_dat[grant];
    end else if (md_busy) begin
      if (abort || kind != 0) begin
        md_busy = 1'b0;
      end else begin
        if (md_stb && !sl_stall) md_stb = 1'b0;
        md_age++;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bit dead;
    clear_inputs();
    do_reset();
    step();

    // single m0 write, slave acks two cycles after the strobe
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
    m_adr[0] = 32'h0; m_sel[0] = 4'hf; m_dat[0] = 32'h1234_5678;
    step();
    check("t1_accept", g_stall[0], 1'b0);
    m_stb[0] = 1'b0;
    step();
    check("t1_stb", g_stb, 1'b1);
    check("t1_sdat", g_sdat, 32'h1234_5678);
    step();
    check("t1_wait_stb", g_stb, 1'b0);
    sl_ack = 1'b1;
    step();
    check("t1_ack0", g_ack[0], 1'b1);
    check("t1_ack1", g_ack[1], 1'b0);
    clear_inputs();
    step();

    // both masters request continuously from reset
    do_reset();
    for (int n = 0; n < 2; n++) begin
      m_cyc[n] = 1'b1; m_stb[n] = 1'b1; m_adr[n] = 32'h100 * (n + 1); m_dat[n] = $urandom;
      ack_cnt[n] = 0;
    end
    sl_ack = 1'b1;
    grants.delete();
    for (int c = 0; c < 8; c++) begin
      step();
      for (int n = 0; n < 2; n++) begin
        if (g_stall[n] == 1'b0) grants.push_back(n);
        if (g_ack[n] == 1'b1) ack_cnt[n]++;
      end
    end
    check("t2_ngrant", grants.size(), 4);
    for (int k = 0; k < grants.size() && k < 4; k++)
      check($sformatf("t2_grant%0d", k), grants[k], k % 2);
    check("t2_acks0", ack_cnt[0], 2);
    check("t2_acks1", ack_cnt[1], 2);
    clear_inputs();
    step();
    step();

    // slave stalls the strobe for three cycles
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0;
    m_adr[1] = 32'h40; m_sel[1] = 4'b0011; m_dat[1] = 32'hcafe_0001;
    step();
    check("t3_accept", g_stall[1], 1'b0);
    m_stb[1] = 1'b0;
    sl_stall = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) sl_stall = 1'b0;
      step();
      check($sformatf("t3_stb%0d", c), g_stb, 1'b1);
      check($sformatf("t3_adr%0d", c), g_adr, 32'h40);
      check($sformatf("t3_dat%0d", c), g_sdat, 32'hcafe_0001);
    end
    step();
    check("t3_wait_stb", g_stb, 1'b0);
    check("t3_wait_cyc", g_cyc, 1'b1);
    sl_ack = 1'b1; sl_dat = 32'h5a5a_0f0f;
    step();
    check("t3_ack1", g_ack[1], 1'b1);
    check("t3_ack0", g_ack[0], 1'b0);
    check("t3_rdat", g_mdat[1], 32'h5a5a_0f0f);
    clear_inputs();
    step();

    // dead slave: timeout error, then a late ack is ignored
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h200;
    step();
    m_stb[0] = 1'b0;
    for (int c = 0; c < TMO; c++) begin
      step();
      check($sformatf("t4_noerr%0d", c), g_err[0], 1'b0);
      check($sformatf("t4_cyc%0d", c), g_cyc, 1'b1);
    end
    step();
    check("t4_err", g_err[0], 1'b1);
    check("t4_cyc_drop", g_cyc, 1'b0);
    sl_ack = 1'b1;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h300;
    step();
    check("t4_next_accept", g_stall[1], 1'b0);
    check("t4_late_ack", g_ack[0], 1'b0);
    clear_inputs();
    step();
    step();

    // owner m1 aborts in WAIT while m0 is pending
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h44;
    step();
    m_stb[1] = 1'b0;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h80; m_dat[0] = 32'hbeef;
    step();
    check("t5_m0_stalled", g_stall[0], 1'b1);
    m_cyc[1] = 1'b0;
    step();
    check("t5_cyc_hold", g_cyc, 1'b1);
    sl_ack = 1'b1;
    step();
    check("t5_cyc_drop", g_cyc, 1'b0);
    check("t5_no_ack1", g_ack[1], 1'b0);
    check("t5_m0_accept", g_stall[0], 1'b0);
    m_stb[0] = 1'b0;
    step();
    check("t5_ack0", g_ack[0], 1'b1);
    clear_inputs();
    step();

    // reset in WAIT drops cyc at once; afterwards a tie goes to m0
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h90;
    step();
    m_stb[0] = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_cyc", s_cyc_o, 1'b0);
    check("t6_async_stall", m0_stall_o, 1'b1);
    model_reset();
    @(posedge clk); #1;
    clear_inputs();
    rst_n = 1'b1;
    for (int n = 0; n < 2; n++) begin
      m_cyc[n] = 1'b1; m_stb[n] = 1'b1;
    end
    step();
    check("t6_tie0", g_stall[0], 1'b0);
    check("t6_tie1", g_stall[1], 1'b1);
    clear_inputs();
    step();
    step();

    // random traffic with periodic dead-slave windows
    for (int i = 0; i < 3000; i++) begin
      dead = (i % 250) < 40;
      for (int n = 0; n < 2; n++) begin
        if (md_busy && md_owner == n) begin
          m_cyc[n] = ($urandom_range(0, 49) != 0);
          m_stb[n] = 1'b0;
        end else begin
          m_cyc[n] = ($urandom_range(0, 9) < 4);
          m_stb[n] = m_cyc[n] & ($urandom_range(0, 1) == 1);
          m_we[n]  = ($urandom_range(0, 1) == 1);
          m_adr[n] = $urandom;
          m_sel[n] = SW'($urandom_range(0, (1 << SW) - 1));
          m_dat[n] = $urandom;
        end
      end
      sl_stall = ($urandom_range(0, 9) < 3);
      sl_ack   = !dead && ($urandom_range(0, 9) < 3);
      sl_err   = !dead && ($urandom_range(0, 19) == 0);
      sl_rty   = !dead && ($urandom_range(0, 19) == 0);
      sl_dat   = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
